// File: rtl/ram_link_pkg.sv
// Shared definitions for the RAM2 serial link: FSM states, default geometry, bit order.
package ram_link_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int ADDR_WIDTH_DEF = 11;
  localparam int DATA_WIDTH_DEF = 192;
  localparam int NUM_DP_DEF     = 5;

  // Must agree with the serial-in writer so a round trip reproduces the stream.
  localparam bit LSB_FIRST = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ram_serial_out_if.sv
// RAM2 read port plus serial-pin and status signals of the serial-out block.
interface ram_serial_out_if #(
  parameter int ADDR_WIDTH = ram_link_pkg::ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = ram_link_pkg::DATA_WIDTH_DEF
);

  logic                  start;
  logic                  ram_oe;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  ser;
  logic                  ser_valid;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, ram_data,
    output ram_oe, ram_addr, ser, ser_valid, busy, done
  );

  modport slave (
    output start, ram_data,
    input  ram_oe, ram_addr, ser, ser_valid, busy, done
  );

endinterface

// File: rtl/piso_shreg.sv
// Parallel-in serial-out shift register, output bit is the next bit on the wire.
// Latency: load/shift take effect at the next rising edge; q is a flop output.
// Backpressure: none; the caller owns the shift enable.
module piso_shreg
  import ram_link_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] d,
  output logic                  q
);

  logic [DATA_WIDTH-1:0] sh;

  // Zero fill means the register is empty (q=0) once a whole word has gone out.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sh <= '0;
    end else if (load) begin
      sh <= d;
    end else if (shift) begin
      sh <= LSB_FIRST ? {1'b0, sh[DATA_WIDTH-1:1]} : {sh[DATA_WIDTH-2:0], 1'b0};
    end
  end

  assign q = LSB_FIRST ? sh[0] : sh[DATA_WIDTH-1];

endmodule

// File: rtl/ram_serial_out.sv
// Reads NUM_DP words from RAM2 at BASE_ADDR.. and shifts each out on one line, LSB first.
// Latency: first bit RD_LAT+1 cycles after start; RD_LAT idle cycles between words.
// Backpressure: none; start while busy is dropped, done holds until restart or RST.
module ram_serial_out
  import ram_link_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_DP     = NUM_DP_DEF,
  parameter int BASE_ADDR  = 0,
  parameter int RD_LAT     = 1
) (
  input logic              CLK,
  input logic              RST,
  ram_serial_out_if.master bus
);

  localparam int BW = clog2(DATA_WIDTH);
  localparam int LW = (clog2(RD_LAT) > 0) ? clog2(RD_LAT) : 1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] widx, widx_nxt;
  logic [BW-1:0]         bcnt, bcnt_nxt;
  logic [LW-1:0]         lcnt, lcnt_nxt;
  logic                  load, shift;
  logic                  ser_q;

  logic last_lat, last_bit, last_word;
  assign last_lat  = (lcnt == LW'(RD_LAT - 1));
  assign last_bit  = (bcnt == BW'(DATA_WIDTH - 1));
  assign last_word = (widx == ADDR_WIDTH'(NUM_DP - 1));

  always_comb begin
    state_nxt = state;
    widx_nxt  = widx;
    bcnt_nxt  = bcnt;
    lcnt_nxt  = lcnt;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = READ;
          widx_nxt  = '0;
          lcnt_nxt  = '0;
        end
      end
      READ: begin
        if (last_lat) begin
          load      = 1'b1;
          state_nxt = SHIFT;
          bcnt_nxt  = '0;
          lcnt_nxt  = '0;
        end else begin
          lcnt_nxt = lcnt + 1'b1;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (last_bit) begin
          bcnt_nxt = '0;
          if (last_word) begin
            state_nxt = DONE;
          end else begin
            widx_nxt  = widx + 1'b1;
            state_nxt = READ;
          end
        end else begin
          bcnt_nxt = bcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the FSM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      widx          <= '0;
      bcnt          <= '0;
      lcnt          <= '0;
      bus.ram_oe    <= 1'b0;
      bus.ram_addr  <= ADDR_WIDTH'(BASE_ADDR);
      bus.ser_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= state_nxt;
      widx          <= widx_nxt;
      bcnt          <= bcnt_nxt;
      lcnt          <= lcnt_nxt;
      bus.ram_oe    <= (state_nxt == READ);
      bus.ram_addr  <= ADDR_WIDTH'(BASE_ADDR) + widx_nxt;
      bus.ser_valid <= (state_nxt == SHIFT);
      bus.busy      <= (state_nxt == READ) || (state_nxt == SHIFT);
      bus.done      <= (state_nxt == DONE);
    end
  end

  piso_shreg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shreg (
    .CLK  (CLK),
    .RST  (RST),
    .load (load),
    .shift(shift),
    .d    (bus.ram_data),
    .q    (ser_q)
  );

  assign bus.ser = ser_q;

endmodule

// File: tb/tb_ram_serial_out.sv
// Bench for ram_serial_out: three configurations against behavioural RAM2 models, bit/address scoreboards.
module tb_ram_serial_out;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // a: 8-bit words, 2 words; b: defaults; c: RD_LAT=3, BASE_ADDR=7, 1 word
  ram_serial_out_if #(.ADDR_WIDTH(11), .DATA_WIDTH(8))   if_a ();
  ram_serial_out_if #(.ADDR_WIDTH(11), .DATA_WIDTH(192)) if_b ();
  ram_serial_out_if #(.ADDR_WIDTH(11), .DATA_WIDTH(192)) if_c ();

  ram_serial_out #(.ADDR_WIDTH(11), .DATA_WIDTH(8), .NUM_DP(2), .BASE_ADDR(0), .RD_LAT(1))
    u_a (.CLK(CLK), .RST(RST), .bus(if_a));
  ram_serial_out #(.ADDR_WIDTH(11), .DATA_WIDTH(192), .NUM_DP(5), .BASE_ADDR(0), .RD_LAT(1))
    u_b (.CLK(CLK), .RST(RST), .bus(if_b));
  ram_serial_out #(.ADDR_WIDTH(11), .DATA_WIDTH(192), .NUM_DP(1), .BASE_ADDR(7), .RD_LAT(3))
    u_c (.CLK(CLK), .RST(RST), .bus(if_c));

  function automatic logic [191:0] ram_word(input int k);
    logic [11:0] v;
    v = 12'hA00 + 12'(k);
    return {16{v}};
  endfunction

  function automatic logic [7:0] small_word(input int k);
    return (k == 0) ? 8'hA5 : (k == 1) ? 8'h3C : 8'h00;
  endfunction

  // RAM2 models: data only appears once oe has been held for RD_LAT cycles.
  int oe_run_c = 0;
  always @(posedge CLK) oe_run_c <= if_c.ram_oe ? oe_run_c + 1 : 0;

  assign if_a.ram_data = if_a.ram_oe ? small_word(int'(if_a.ram_addr)) : '0;
  assign if_b.ram_data = if_b.ram_oe ? ram_word(int'(if_b.ram_addr)) : '0;
  assign if_c.ram_data = (if_c.ram_oe && oe_run_c >= 2) ? ram_word(int'(if_c.ram_addr)) : '0;

  bit q_a[$], q_b[$], q_c[$];
  int qa_a[$], qa_b[$], qa_c[$];
  int bits_b = 0;
  logic oe_prev_a = 1'b0, oe_prev_b = 1'b0, oe_prev_c = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (if_a.ser_valid) begin
      if (q_a.size() == 0) chk("a_bit_unexpected", 64'(if_a.ser_valid), 64'd0);
      else chk("a_bit", 64'(if_a.ser), 64'(q_a.pop_front()));
    end
    if (if_a.ram_oe && !oe_prev_a) begin
      if (qa_a.size() == 0) chk("a_read_unexpected", 64'(if_a.ram_oe), 64'd0);
      else chk("a_addr", 64'(if_a.ram_addr), 64'(qa_a.pop_front()));
    end
    oe_prev_a <= if_a.ram_oe;
  end

  always @(negedge CLK) begin
    if (if_b.ser_valid) begin
      if (q_b.size() == 0) chk("b_bit_unexpected", 64'(if_b.ser_valid), 64'd0);
      else chk("b_bit", 64'(if_b.ser), 64'(q_b.pop_front()));
      bits_b <= bits_b + 1;
    end
    if (if_b.ram_oe && !oe_prev_b) begin
      if (qa_b.size() == 0) chk("b_read_unexpected", 64'(if_b.ram_oe), 64'd0);
      else chk("b_addr", 64'(if_b.ram_addr), 64'(qa_b.pop_front()));
    end
    oe_prev_b <= if_b.ram_oe;
  end

  always @(negedge CLK) begin
    if (if_c.ser_valid) begin
      if (q_c.size() == 0) chk("c_bit_unexpected", 64'(if_c.ser_valid), 64'd0);
      else chk("c_bit", 64'(if_c.ser), 64'(q_c.pop_front()));
    end
    if (if_c.ram_oe && !oe_prev_c) begin
      if (qa_c.size() == 0) chk("c_read_unexpected", 64'(if_c.ram_oe), 64'd0);
      else chk("c_addr", 64'(if_c.ram_addr), 64'(qa_c.pop_front()));
    end
    oe_prev_c <= if_c.ram_oe;
  end

  // Queue the expected stream, then pulse start so it is sampled at edge 0.
  // Returns #1 after edge 0, i.e. while observing cycle 1.
  task automatic pulse(input int sel);
    logic [191:0] wd;
    logic [7:0]   ws;
    case (sel)
      0: for (int w = 0; w < 2; w++) begin
           ws = small_word(w);
           for (int b = 0; b < 8; b++) q_a.push_back(ws[b]);
           qa_a.push_back(w);
         end
      1: for (int w = 0; w < 5; w++) begin
           wd = ram_word(w);
           for (int b = 0; b < 192; b++) q_b.push_back(wd[b]);
           qa_b.push_back(w);
         end
      default: begin
           wd = ram_word(7);
           for (int b = 0; b < 192; b++) q_c.push_back(wd[b]);
           qa_c.push_back(7);
         end
    endcase
    @(posedge CLK); #1;
    case (sel)
      0: if_a.start = 1'b1;
      1: if_b.start = 1'b1;
      default: if_c.start = 1'b1;
    endcase
    @(posedge CLK); #1;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    if_c.start = 1'b0;
  endtask

  // Observes cycles 1,2,... until done; n is the first cycle with done=1 (-1 on timeout).
  task automatic wait_done(input int sel, input int pulse_at, output int n,
                           output int oe_cnt, output logic [63:0] vh);
    logic v, o, d;
    n = -1; oe_cnt = 0; vh = '0;
    for (int c = 1; c <= 3000; c++) begin
      if (c > 1) begin
        @(posedge CLK); #1;
        if_b.start = 1'b0;
      end
      if (c == pulse_at) if_b.start = 1'b1;
      case (sel)
        0: {v, o, d} = {if_a.ser_valid, if_a.ram_oe, if_a.done};
        1: {v, o, d} = {if_b.ser_valid, if_b.ram_oe, if_b.done};
        default: {v, o, d} = {if_c.ser_valid, if_c.ram_oe, if_c.done};
      endcase
      if (c < 64) vh[c] = v;
      if (o) oe_cnt++;
      if (d) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    int n, oc, cnt, b0;
    bit found;
    logic [63:0] vh, ev;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    if_c.start = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // idle after reset: everything at reset values, ram_addr = BASE_ADDR
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      chk("a_idle", {if_a.ram_oe, if_a.ram_addr, if_a.ser, if_a.ser_valid, if_a.busy, if_a.done}, 64'd0);
      chk("b_idle", {if_b.ram_oe, if_b.ram_addr, if_b.ser, if_b.ser_valid, if_b.busy, if_b.done}, 64'd0);
      chk("c_idle", {if_c.ram_oe, if_c.ram_addr, if_c.ser, if_c.ser_valid, if_c.busy, if_c.done}, 64'd7 << 4);
    end

    // 8-bit words A5, 3C: valid in cycles 2..9 and 11..18, done at 19
    pulse(0);
    wait_done(0, -1, n, oc, vh);
    ev = '0;
    for (int c = 2; c <= 9; c++) ev[c] = 1'b1;
    for (int c = 11; c <= 18; c++) ev[c] = 1'b1;
    chk("a_done_cycle", 64'(n), 64'd19);
    chk("a_valid_map", vh, ev);
    chk("a_oe_cycles", 64'(oc), 64'd2);

    // defaults, with a start pulse during word 2 that must be ignored
    pulse(1);
    wait_done(1, 450, n, oc, vh);
    chk("b_done_cycle", 64'(n), 64'd966);
    chk("b_oe_cycles", 64'(oc), 64'd5);
    cnt = 0;
    repeat (50) begin
      @(posedge CLK); #1;
      if (if_b.done && !if_b.busy && !if_b.ser_valid) cnt++;
    end
    chk("b_done_hold", 64'(cnt), 64'd50);

    // restart from DONE: done clears at once, identical stream follows
    pulse(1);
    chk("b_restart_done_busy", {if_b.done, if_b.busy}, 64'b01);
    wait_done(1, -1, n, oc, vh);
    chk("b_done_cycle2", 64'(n), 64'd966);

    // abort with RST at bit 100 of word 3, then resend from BASE_ADDR
    pulse(1);
    b0 = bits_b;
    found = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (if_b.ser_valid && (bits_b - b0) == 676) begin
        found = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
    chk("b_reach_abort_bit", 64'(found), 64'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("b_after_rst", {if_b.ram_oe, if_b.ram_addr, if_b.ser, if_b.ser_valid, if_b.busy, if_b.done}, 64'd0);
    RST = 1'b0;
    q_b.delete();
    qa_b.delete();
    pulse(1);
    wait_done(1, -1, n, oc, vh);
    chk("b_done_after_abort", 64'(n), 64'd966);
    chk("b_oe_after_abort", 64'(oc), 64'd5);

    // RD_LAT=3, BASE_ADDR=7, one word
    pulse(2);
    wait_done(2, -1, n, oc, vh);
    chk("c_done_cycle", 64'(n), 64'd196);
    chk("c_oe_cycles", 64'(oc), 64'd3);
    chk("c_first_valid", vh[4:1], 64'b1000);

    repeat (3) @(posedge CLK);
    #1;
    chk("a_bits_left", 64'(q_a.size()), 64'd0);
    chk("b_bits_left", 64'(q_b.size()), 64'd0);
    chk("c_bits_left", 64'(q_c.size()), 64'd0);
    chk("a_reads_left", 64'(qa_a.size()), 64'd0);
    chk("b_reads_left", 64'(qa_b.size()), 64'd0);
    chk("c_reads_left", 64'(qa_c.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
